// File: rtl/fifo_read_stream_adapter.sv
// Read-domain drain for the async FIFO: turns rd_en/empty/registered data_out
// into a registered valid/ready stream via a 2-entry in-order skid buffer.
module fifo_read_stream_adapter #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   rd_clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_rd_en,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [COUNT_WIDTH-1:0] words_read
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  // m_data is the buffer head; second_q is the entry behind it.
  logic [1:0]            occ;
  logic [1:0]            occ_nxt;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] second_q;
  logic                  pop;
  logic [2:0]            committed;

  assign pop = m_valid & m_ready;

  // Slots already spoken for after this edge: stored + returning - leaving.
  // pop implies occ >= 1, so this never goes negative.
  assign committed  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = !rst & !fifo_empty & (committed < 3'd2);

  always_comb begin
    occ_nxt = occ;
    case ({inflight, pop})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      occ        <= 2'd0;
      inflight   <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      second_q   <= '0;
      words_read <= '0;
    end else begin
      // A read issued just before reset is dropped because inflight clears.
      inflight <= fifo_rd_en;
      occ      <= occ_nxt;
      m_valid  <= (occ_nxt != 2'd0);

      if (pop) begin
        if (occ == 2'd2)
          m_data <= second_q;
        else if (inflight)
          m_data <= fifo_data;
      end else if (inflight && occ == 2'd0) begin
        m_data <= fifo_data;
      end

      if (inflight && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop)))
        second_q <= fifo_data;

      if (pop)
        words_read <= words_read + CNT_ONE;
    end
  end

  a_no_overflow: assert property (@(posedge rd_clk) disable iff (rst)
    !(inflight && occ == 2'd2 && !pop));

  a_no_read_when_empty: assert property (@(posedge rd_clk) disable iff (rst)
    !(fifo_rd_en && fifo_empty));

endmodule

// File: tb/tb_fifo_read_stream_adapter.sv
// Bench for fifo_read_stream_adapter: queue-based FIFO model plus a
// scoreboard of words read but not yet delivered.
module tb_fifo_read_stream_adapter;
  localparam int DW  = 8;
  localparam int CW  = 16;
  localparam int CWW = 4;

  logic           rd_clk = 1'b0;
  logic           rst = 1'b1;
  logic           fifo_empty = 1'b1;
  logic [DW-1:0]  fifo_data = '0;
  logic           m_ready = 1'b0;
  logic           fifo_rd_en, fifo_rd_en_w, m_valid, m_valid_w;
  logic [DW-1:0]  m_data, m_data_w;
  logic [CW-1:0]  words_read;
  logic [CWW-1:0] words_read_w;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] fq[$];     // words held by the FIFO
  logic [DW-1:0] exp_q[$];  // words read from the FIFO, not yet transferred
  logic [DW-1:0] got_q[$];  // transfers observed on the stream
  logic [DW-1:0] sent[$];
  int xfers = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  fifo_read_stream_adapter #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .rd_clk(rd_clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .words_read(words_read));

  fifo_read_stream_adapter #(.DATA_WIDTH(DW), .COUNT_WIDTH(CWW)) dut_w (
    .rd_clk(rd_clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en_w), .m_data(m_data_w), .m_valid(m_valid_w),
    .m_ready(m_ready), .words_read(words_read_w));

  always #5 rd_clk = ~rd_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // FIFO read port: registered data_out, one word per accepted read.
  logic [DW-1:0] fw;
  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      chk("read_nonempty", 32'(fq.size() != 0), 32'd1);
      if (fq.size() != 0) begin
        fw = fq.pop_front();
        fifo_data <= fw;
        exp_q.push_back(fw);
      end
    end
  end

  task automatic monitor();
    if (rst) begin
      chk("rd_en_in_reset", 32'(fifo_rd_en), 32'd0);
      exp_q.delete();
      xfers = 0;
      prev_stall = 1'b0;
    end else begin
      chk("words_read", 32'(words_read), 32'(xfers % (1 << CW)));
      chk("words_read_w", 32'(words_read_w), 32'(xfers % (1 << CWW)));
      chk("rd_en_while_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
      chk("rd_en_w_while_empty", 32'(fifo_rd_en_w & fifo_empty), 32'd0);
      chk("outstanding_le2", 32'(exp_q.size() <= 2), 32'd1);
      if (prev_stall) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        chk("read_before_xfer", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("stream_order", 32'(m_data), 32'(exp_q[0]));
          chk("twin_order", 32'({m_valid_w, m_data_w}), 32'({1'b1, exp_q[0]}));
          void'(exp_q.pop_front());
        end
        got_q.push_back(m_data);
        xfers++;
      end
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
    end
  endtask

  task automatic step(input logic r, input logic rdy, input logic g);
    @(negedge rd_clk);
    rst        = r;
    m_ready    = rdy;
    fifo_empty = g | (fq.size() == 0);
    #1;
    monitor();
  endtask

  typedef struct {
    logic          r;
    logic          push;
    logic [DW-1:0] word;
    logic          rdy;
    logic          rd_en;
    logic          vld;
    logic          chk_d;
    logic [DW-1:0] data;
    int            wr;
  } vec_t;

  vec_t vecs[17];
  int first_v, last_v, n_v, rd_cnt, pushed;
  logic [DW-1:0] rw;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    // reset with A5 waiting, single-word read, then a short backpressure run
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 0};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1};
    vecs[8]  = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1};
    vecs[9]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1};
    vecs[10] = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 2};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 3};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 4};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5};

    fq.push_back(8'hA5);
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].push) fq.push_back(vecs[i].word);
      step(vecs[i].r, vecs[i].rdy, 1'b0);
      chk($sformatf("vec%0d_rd_en", i), 32'(fifo_rd_en), 32'(vecs[i].rd_en));
      chk($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(vecs[i].vld));
      if (vecs[i].chk_d)
        chk($sformatf("vec%0d_data", i), 32'(m_data), 32'(vecs[i].data));
      chk($sformatf("vec%0d_words_read", i), 32'(words_read), 32'(vecs[i].wr));
    end

    // streaming: 16 words with ready held high, no bubbles
    got_q.delete();
    for (int i = 0; i < 16; i++) fq.push_back(DW'(i));
    first_v = -1; last_v = -1; n_v = 0;
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 1'b1, 1'b0);
      if (m_valid) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        n_v++;
      end
    end
    chk("stream_valid_cycles", 32'(n_v), 32'd16);
    chk("stream_contiguous", 32'(last_v - first_v + 1), 32'd16);
    chk("stream_count", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      chk("stream_word", 32'(got_q[i]), 32'(i));
    chk("stream_words_read", 32'(words_read), 32'd21);

    // backpressure: 8 queued, ready low -> exactly two reads, head held
    got_q.delete();
    for (int i = 0; i < 8; i++) fq.push_back(DW'(i));
    rd_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b0, 1'b0);
      if (fifo_rd_en) rd_cnt++;
      if (c >= 2) begin
        chk("bp_valid", 32'(m_valid), 32'd1);
        chk("bp_data", 32'(m_data), 32'h00);
      end
    end
    chk("bp_reads", 32'(rd_cnt), 32'd2);
    for (int c = 0; c < 12; c++) step(1'b0, 1'b1, 1'b0);
    chk("bp_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      chk("bp_word", 32'(got_q[i]), 32'(i));
    chk("bp_words_read", 32'(words_read), 32'd29);

    // random ready and FIFO empty gaps
    got_q.delete();
    sent.delete();
    pushed = 0;
    for (int c = 0; c < 4000 && got_q.size() < 200; c++) begin
      if (pushed < 200 && $urandom_range(3) != 0) begin
        rw = DW'($urandom);
        fq.push_back(rw);
        sent.push_back(rw);
        pushed++;
      end
      step(1'b0, 1'($urandom_range(1)), ($urandom_range(3) == 0));
    end
    chk("rand_count", 32'(got_q.size()), 32'd200);
    for (int i = 0; i < 200 && i < got_q.size(); i++)
      chk("rand_word", 32'(got_q[i]), 32'(sent[i]));
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 1'b0);
    chk("rand_words_read", 32'(words_read), 32'd229);

    // reset in the cycle after a read issues: that word is lost
    for (int i = 0; i < 8; i++) fq.push_back(DW'(8'h50 + i));
    step(1'b0, 1'b0, 1'b0);
    chk("mid_rd_en_issue", 32'(fifo_rd_en), 32'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("mid_rd_en_reset", 32'(fifo_rd_en), 32'd0);
    got_q.delete();
    for (int c = 0; c < 14; c++) step(1'b0, 1'b1, 1'b0);
    chk("mid_count", 32'(got_q.size()), 32'd7);
    for (int i = 0; i < 7 && i < got_q.size(); i++)
      chk("mid_word", 32'(got_q[i]), 32'(8'h51 + i));
    chk("mid_words_read", 32'(words_read), 32'd7);

    // counter wrap on the 4-bit instance
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) fq.push_back(DW'(8'hC0 + i));
    for (int c = 0; c < 24; c++) step(1'b0, 1'b1, 1'b0);
    chk("wrap_words_read_w", 32'(words_read_w), 32'd1);
    chk("wrap_words_read", 32'(words_read), 32'd17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
